// File: rtl/alu_fp_pkg.sv
// Shared widths, bias and FSM state encoding for the FP multiply mantissa path.
package alu_fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 24;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_operand_unpack.sv
// Splits an IEEE-754 single into sign, exponent and hidden-bit mantissa,
// and flags zero and all-ones-exponent (inf/NaN) operands.
module fp_operand_unpack
  import alu_fp_pkg::*;
#(
  parameter int P_EXP_W  = EXP_W,
  parameter int P_MANT_W = MANT_W
) (
  input  logic [31:0]         i_op,
  output logic                o_sign,
  output logic [P_EXP_W-1:0]  o_exp,
  output logic [P_MANT_W-1:0] o_mant,
  output logic                o_is_zero,
  output logic                o_is_special
);

  localparam int FRAC_W = P_MANT_W - 1;

  logic [FRAC_W-1:0] w_frac;

  assign o_sign       = i_op[31];
  assign o_exp        = i_op[30 -: P_EXP_W];
  assign w_frac       = i_op[FRAC_W-1:0];
  // Denormals keep a zero hidden bit and their raw exponent.
  assign o_mant       = {(o_exp != '0), w_frac};
  assign o_is_zero    = (o_exp == '0) && (w_frac == '0);
  assign o_is_special = (o_exp == P_EXP_W'(EXP_MAX));

endmodule

// File: rtl/multiplication_mantissa_core.sv
// Sequential FP multiply front end: sign, biased exponent sum with range flags,
// and a radix-2 shift-add mantissa product formed one partial product per cycle.
module multiplication_mantissa_core
  import alu_fp_pkg::*;
#(
  parameter int P_EXP_W  = EXP_W,
  parameter int P_MANT_W = MANT_W,
  parameter int P_BIAS   = BIAS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_s,
  output logic [P_EXP_W-1:0]    out_e,
  output logic [2*P_MANT_W-1:0] out_m,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic                  out_unf
);

  localparam int SUM_W = P_EXP_W + 2;
  localparam int CNT_W = $clog2(P_MANT_W);
  localparam logic signed [SUM_W-1:0] SUM_BIAS = SUM_W'(P_BIAS);
  localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'(EXP_MAX - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(P_MANT_W - 1);

  logic                    w_sign_a, w_sign_b;
  logic [P_EXP_W-1:0]      w_exp_a, w_exp_b;
  logic [P_MANT_W-1:0]     w_mant_a, w_mant_b;
  logic                    w_zero_a, w_zero_b, w_spec_a, w_spec_b;
  logic signed [SUM_W-1:0] w_esum;
  logic                    w_zero, w_ovf, w_unf;

  state_t                  r_state;
  logic [2*P_MANT_W-1:0]   r_mcand;
  logic [P_MANT_W-1:0]     r_mplier;
  logic [2*P_MANT_W-1:0]   r_acc;
  logic [CNT_W-1:0]        r_cnt;

  fp_operand_unpack #(.P_EXP_W(P_EXP_W), .P_MANT_W(P_MANT_W)) u_unpack_a (
    .i_op(in_a), .o_sign(w_sign_a), .o_exp(w_exp_a), .o_mant(w_mant_a),
    .o_is_zero(w_zero_a), .o_is_special(w_spec_a)
  );

  fp_operand_unpack #(.P_EXP_W(P_EXP_W), .P_MANT_W(P_MANT_W)) u_unpack_b (
    .i_op(in_b), .o_sign(w_sign_b), .o_exp(w_exp_b), .o_mant(w_mant_b),
    .o_is_zero(w_zero_b), .o_is_special(w_spec_b)
  );

  // Two guard bits keep the full signed sum so the flags see the true range.
  assign w_esum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - SUM_BIAS;
  assign w_zero = w_zero_a || w_zero_b;
  assign w_ovf  = (w_esum > SUM_MAX) || w_spec_a || w_spec_b;
  assign w_unf  = (w_esum[SUM_W-1] || (w_esum == '0)) && !w_zero;

  assign out_m = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            out_s    <= w_sign_a ^ w_sign_b;
            out_zero <= w_zero;
            out_ovf  <= w_ovf;
            out_unf  <= w_unf;
            r_mcand  <= {{P_MANT_W{1'b0}}, w_mant_a};
            r_mplier <= w_mant_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            // A zero operand skips the multiply entirely.
            if (w_zero) begin
              out_e     <= '0;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              out_e   <= w_esum[P_EXP_W-1:0];
              r_state <= MUL;
            end
          end
        end
        MUL: begin
          if (r_mplier[r_cnt]) r_acc <= r_acc + (r_mcand << r_cnt);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication_mantissa_core.sv
// Scoreboard bench for multiplication_mantissa_core: a behavioural model pushes the
// expected result on every accept, and it is popped and compared when out_valid rises.
module tb_multiplication_mantissa_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        out_s, out_zero, out_ovf, out_unf;
  logic [7:0]  out_e;
  logic [47:0] out_m;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [47:0] m;
    logic        zero;
    logic        ovf;
    logic        unf;
    int          lat;
  } expect_t;

  expect_t sbQueue[$];
  int compared   = 0;
  int mismatched = 0;

  multiplication_mantissa_core dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_m(out_m),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic expect_t modelOp(input logic [31:0] a, input logic [31:0] b);
    expect_t     r;
    int          ea, eb, sum;
    logic [47:0] ma, mb;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    sum    = ea + eb - 127;
    ma     = {24'd0, (ea != 0), a[22:0]};
    mb     = {24'd0, (eb != 0), b[22:0]};
    r.zero = (ea == 0 && a[22:0] == 0) || (eb == 0 && b[22:0] == 0);
    r.s    = a[31] ^ b[31];
    r.m    = r.zero ? 48'd0 : ma * mb;
    r.e    = r.zero ? 8'd0 : sum[7:0];
    r.ovf  = (sum > 254) || (ea == 255) || (eb == 255);
    r.unf  = (sum < 1) && !r.zero;
    r.lat  = r.zero ? 1 : 25;
    return r;
  endfunction

  // Drives one operand pair, waits for the result, compares it, then releases DONE.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int hold);
    expect_t e;
    int      lat;
    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    sbQueue.push_back(modelOp(a, b));
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sbQueue.pop_front();
    if (!out_valid) begin
      checkOutput("valid_timeout", out_valid, 1);
      return;
    end
    checkOutput("latency", lat, e.lat);
    checkOutput("out_s", out_s, e.s);
    checkOutput("out_e", out_e, e.e);
    checkOutput("out_m", out_m, e.m);
    checkOutput("out_zero", out_zero, e.zero);
    checkOutput("out_ovf", out_ovf, e.ovf);
    checkOutput("out_unf", out_unf, e.unf);
    checkOutput("in_ready_busy", in_ready, 0);
    if (hold > 0) begin
      in_a     = ~a;
      in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_m", out_m, e.m);
        checkOutput("hold_e", out_e, e.e);
        checkOutput("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("valid_drop", out_valid, 0);
    checkOutput("in_ready_back", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_m", out_m, 0);
    checkOutput("rst_out_e", out_e, 0);
    checkOutput("rst_flags", {out_s, out_zero, out_ovf, out_unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h3F800000, 32'h3F800000, 0);
    applyStimulus(32'h40000000, 32'hC0400000, 0);
    applyStimulus(32'h3FC00000, 32'h3FC00000, 0);
    applyStimulus(32'h00000000, 32'h3F800000, 0);
    applyStimulus(32'h7F000000, 32'h7F000000, 0);
    applyStimulus(32'h00800000, 32'h00800000, 0);
    applyStimulus(32'h40000000, 32'hC0400000, 10);
    applyStimulus(32'h7F800000, 32'h3F800000, 0);
    applyStimulus(32'h00400000, 32'h3FFFFFFF, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom, $urandom, i % 3);
    end

    // Abort mid-multiply: outputs must clear at once and no result may follow.
    @(negedge clk);
    in_a     = 32'hBFC00000;
    in_b     = 32'h3F800001;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("pre_rst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out_m", out_m, 0);
    checkOutput("abort_out_e", out_e, 0);
    checkOutput("abort_flags", {out_s, out_zero, out_ovf, out_unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      checkOutput("abort_no_valid", out_valid, 0);
    end
    checkOutput("scoreboard_empty", sbQueue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
